// File: rtl/cnn_classifier_learn.sv
// Two-layer fully-connected classifier head (FC1 + ReLU, FC2, argmax) with
// on-line weight updates applied once per inference pass.
module cnn_classifier_learn #(
    parameter int unsigned INPUT_SIZE     = 20,
    parameter int unsigned HIDDEN_NEURONS = 64,
    parameter int unsigned CLASS_COUNT    = 8,
    parameter int unsigned WEIGHT_W       = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [32*INPUT_SIZE-1:0]    features_in_flat,
    input  logic [7:0]                  label_in,
    input  logic                        label_in_valid,
    input  logic                        anomaly_flag,
    output logic [7:0]                  class_label
);

    localparam int unsigned HW = $clog2(HIDDEN_NEURONS);
    localparam int unsigned CW = $clog2(CLASS_COUNT);
    localparam logic [HW-1:0] H_LAST = HW'(HIDDEN_NEURONS - 1);
    localparam logic [CW-1:0] C_LAST = CW'(CLASS_COUNT - 1);
    localparam logic signed [WEIGHT_W-1:0] W_MAX = {1'b0, {(WEIGHT_W-1){1'b1}}};
    localparam logic signed [WEIGHT_W-1:0] W_MIN = {1'b1, {(WEIGHT_W-1){1'b0}}};
    localparam logic signed [45:0] HIDDEN_CAP = 46'sh0000_7FFF_FFFF;

    typedef enum logic [1:0] {StLoad, StFc1, StFc2, StDone} state_e;

    state_e                     state_q;
    logic [HW-1:0]              h_idx_q;
    logic [CW-1:0]              c_idx_q;
    logic signed [31:0]         features_q [INPUT_SIZE];
    logic [31:0]                hidden [HIDDEN_NEURONS];
    logic signed [WEIGHT_W-1:0] fc1_weights [HIDDEN_NEURONS][INPUT_SIZE];
    logic signed [WEIGHT_W-1:0] fc2_weights [CLASS_COUNT][HIDDEN_NEURONS];
    logic signed [47:0]         best_score_q;
    logic [CW-1:0]              best_idx_q;
    logic                       pend_sup_q;
    logic                       pend_anom_q;
    logic [7:0]                 pend_label_q;

    logic signed [45:0]         fc1_acc;
    logic [31:0]                hidden_next;
    logic signed [47:0]         fc2_score;
    logic                       label_ok;

    function automatic logic signed [WEIGHT_W-1:0] sat_inc(input logic signed [WEIGHT_W-1:0] w);
        return (w == W_MAX) ? w : w + WEIGHT_W'(1);
    endfunction

    function automatic logic signed [WEIGHT_W-1:0] sat_dec(input logic signed [WEIGHT_W-1:0] w);
        return (w == W_MIN) ? w : w - WEIGHT_W'(1);
    endfunction

    // FC1 dot product for the current neuron, followed by ReLU and 31-bit clamp
    always_comb begin
        fc1_acc = '0;
        for (int i = 0; i < INPUT_SIZE; i++) begin
            fc1_acc = fc1_acc + 46'(features_q[i]) * 46'(fc1_weights[h_idx_q][i]);
        end
        if (fc1_acc <= 46'sd0) begin
            hidden_next = '0;
        end else if (fc1_acc > HIDDEN_CAP) begin
            hidden_next = 32'h7FFF_FFFF;
        end else begin
            hidden_next = fc1_acc[31:0];
        end
    end

    // FC2 score for the current class; hidden values are non-negative
    always_comb begin
        fc2_score = '0;
        for (int h = 0; h < HIDDEN_NEURONS; h++) begin
            fc2_score = fc2_score
                      + 48'($signed({1'b0, hidden[h]})) * 48'(fc2_weights[c_idx_q][h]);
        end
        label_ok = (pend_label_q < 8'(CLASS_COUNT));
    end

    // Pass sequencing, feature capture, hidden layer, argmax and update flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StLoad;
            h_idx_q      <= '0;
            c_idx_q      <= '0;
            best_score_q <= '0;
            best_idx_q   <= '0;
            class_label  <= '0;
            pend_sup_q   <= 1'b0;
            pend_anom_q  <= 1'b0;
            pend_label_q <= '0;
            for (int i = 0; i < INPUT_SIZE; i++) features_q[i] <= '0;
            for (int h = 0; h < HIDDEN_NEURONS; h++) hidden[h] <= '0;
        end else begin
            // Flags seen in DONE belong to the next pass, since DONE consumes the old ones
            pend_sup_q  <= label_in_valid | (pend_sup_q & (state_q != StDone));
            pend_anom_q <= anomaly_flag | (pend_anom_q & (state_q != StDone));
            if (label_in_valid) pend_label_q <= label_in;

            unique case (state_q)
                StLoad: begin
                    for (int i = 0; i < INPUT_SIZE; i++) begin
                        features_q[i] <= features_in_flat[32*i +: 32];
                    end
                    h_idx_q <= '0;
                    state_q <= StFc1;
                end
                StFc1: begin
                    hidden[h_idx_q] <= hidden_next;
                    h_idx_q         <= h_idx_q + 1'b1;
                    if (h_idx_q == H_LAST) begin
                        c_idx_q <= '0;
                        state_q <= StFc2;
                    end
                end
                StFc2: begin
                    // Strictly-greater replacement keeps the lowest index on ties
                    if (c_idx_q == '0 || fc2_score > best_score_q) begin
                        best_score_q <= fc2_score;
                        best_idx_q   <= c_idx_q;
                    end
                    c_idx_q <= c_idx_q + 1'b1;
                    if (c_idx_q == C_LAST) state_q <= StDone;
                end
                StDone: begin
                    class_label <= {{(8-CW){1'b0}}, best_idx_q};
                    state_q     <= StLoad;
                end
                default: state_q <= StLoad;
            endcase
        end
    end

    // Weight storage: init on reset, learning updates in the DONE cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int h = 0; h < HIDDEN_NEURONS; h++) begin
                for (int i = 0; i < INPUT_SIZE; i++) begin
                    fc1_weights[h][i] <= WEIGHT_W'(1);
                end
            end
            for (int c = 0; c < CLASS_COUNT; c++) begin
                for (int h = 0; h < HIDDEN_NEURONS; h++) begin
                    fc2_weights[c][h] <= WEIGHT_W'(c - 3);
                end
            end
        end else if (state_q == StDone) begin
            if (pend_anom_q) begin
                for (int h = 0; h < HIDDEN_NEURONS; h++) begin
                    for (int i = 0; i < INPUT_SIZE; i++) begin
                        fc1_weights[h][i] <= sat_inc(fc1_weights[h][i]);
                    end
                end
            end
            if (pend_sup_q && label_ok) begin
                for (int h = 0; h < HIDDEN_NEURONS; h++) begin
                    if (hidden[h] != '0) begin
                        for (int c = 0; c < CLASS_COUNT; c++) begin
                            if (c == int'(pend_label_q)) begin
                                fc2_weights[c][h] <= sat_inc(fc2_weights[c][h]);
                            end else if (c == int'(best_idx_q)) begin
                                fc2_weights[c][h] <= sat_dec(fc2_weights[c][h]);
                            end
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_cnn_classifier_learn.sv
// Directed bench for cnn_classifier_learn: pass timing is tracked by counting
// rising edges since reset release (LOAD on edge 1, DONE on every 74th edge).
module tb_cnn_classifier_learn;

    logic         clk;
    logic         rst;
    logic [639:0] features_in_flat;
    logic [7:0]   label_in;
    logic         label_in_valid;
    logic         anomaly_flag;
    logic [7:0]   class_label;

    int checks   = 0;
    int failures = 0;
    int edge_cnt = 0;

    cnn_classifier_learn dut (
        .clk              (clk),
        .rst              (rst),
        .features_in_flat (features_in_flat),
        .label_in         (label_in),
        .label_in_valid   (label_in_valid),
        .anomaly_flag     (anomaly_flag),
        .class_label      (class_label)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input longint actual, input longint expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        edge_cnt++;
    endtask

    task automatic run_to(input int target);
        while (edge_cnt < target) tick();
    endtask

    task automatic set_features(input logic [31:0] v);
        for (int i = 0; i < 20; i++) features_in_flat[32*i +: 32] = v;
    endtask

    initial begin
        rst            = 1'b1;
        label_in       = '0;
        label_in_valid = 1'b0;
        anomaly_flag   = 1'b0;
        set_features(32'd1);
        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_label", class_label, 0);
        check("reset_hidden0", dut.hidden[0], 0);
        check("reset_fc1_0_0", dut.fc1_weights[0][0], 1);
        check("reset_fc2_0_0", dut.fc2_weights[0][0], -3);
        check("reset_fc2_7_63", dut.fc2_weights[7][63], 4);
        @(negedge clk);
        rst = 1'b1;
        edge_cnt = 0;

        // Pass 1: features 1 -> hidden 20, class 7
        run_to(73);
        check("p1_latency", class_label, 0);
        run_to(74);
        check("p1_label", class_label, 7);
        check("p1_hidden0", dut.hidden[0], 20);
        check("p1_hidden63", dut.hidden[63], 20);
        check("p1_fc1_0_0", dut.fc1_weights[0][0], 1);

        // Pass 2: anomaly for 20 cycles -> every fc1 weight becomes 2
        run_to(80);
        anomaly_flag = 1'b1;
        run_to(100);
        anomaly_flag = 1'b0;
        run_to(147);
        check("p2_no_early_upd", dut.fc1_weights[0][0], 1);
        run_to(148);
        check("p2_fc1_0_0", dut.fc1_weights[0][0], 2);
        check("p2_fc1_63_19", dut.fc1_weights[63][19], 2);
        check("p2_label", class_label, 7);

        // Pass 3: hidden doubles
        run_to(222);
        check("p3_hidden5", dut.hidden[5], 40);
        check("p3_label", class_label, 7);

        // Pass 4: supervised label 3 while prediction is 7
        run_to(230);
        label_in       = 8'd3;
        label_in_valid = 1'b1;
        run_to(250);
        label_in_valid = 1'b0;
        run_to(296);
        check("p4_fc2_3_0", dut.fc2_weights[3][0], 1);
        check("p4_fc2_3_63", dut.fc2_weights[3][63], 1);
        check("p4_fc2_7_0", dut.fc2_weights[7][0], 3);
        check("p4_fc2_0_0", dut.fc2_weights[0][0], -3);
        check("p4_label", class_label, 7);

        // Pass 5: rows 6 and 7 now both weigh 3 -> tie resolves to 6
        run_to(370);
        check("p5_tie_label", class_label, 6);
        set_features(32'd2);
        run_to(444);
        check("f2_hidden0", dut.hidden[0], 80);
        check("f2_label", class_label, 6);
        set_features(32'd3);
        run_to(518);
        check("f3_hidden0", dut.hidden[0], 120);
        check("f3_label", class_label, 6);
        set_features(32'd4);
        run_to(592);
        check("f4_hidden0", dut.hidden[0], 160);
        check("f4_label", class_label, 6);
        check("f4_fc1_same", dut.fc1_weights[0][0], 2);
        check("f4_fc2_same", dut.fc2_weights[7][0], 3);

        // Mid-pass feature change is ignored until the next LOAD
        run_to(600);
        set_features(32'hFF);
        run_to(610);
        check("midpass_hidden10", dut.hidden[10], 160);

        // Asynchronous reset mid-pass restores init state immediately
        rst = 1'b0;
        #1;
        check("rst_label", class_label, 0);
        check("rst_fc1_0_0", dut.fc1_weights[0][0], 1);
        check("rst_fc2_7_0", dut.fc2_weights[7][0], 4);
        check("rst_fc2_3_0", dut.fc2_weights[3][0], 0);
        check("rst_hidden10", dut.hidden[10], 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        edge_cnt = 0;

        // Pass A: features 0xFF captured; out-of-range label is ignored
        run_to(1);
        set_features(32'd0);
        run_to(5);
        label_in       = 8'd9;
        label_in_valid = 1'b1;
        run_to(6);
        label_in_valid = 1'b0;
        run_to(73);
        check("pa_latency", class_label, 0);
        run_to(74);
        check("pa_label", class_label, 7);
        check("pa_hidden0", dut.hidden[0], 5100);
        check("pa_fc2_7_0", dut.fc2_weights[7][0], 4);
        check("pa_fc2_0_63", dut.fc2_weights[0][63], -3);
        check("pa_fc2_1_0", dut.fc2_weights[1][0], -2);
        check("pa_fc1_0_0", dut.fc1_weights[0][0], 1);

        // Pass B: all-zero features -> all scores tie at 0 -> class 0
        run_to(148);
        check("pb_hidden0", dut.hidden[0], 0);
        check("pb_label", class_label, 0);
        check("pb_fc2_7_5", dut.fc2_weights[7][5], 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
